// File: rtl/seg_disp_pkg.sv
// Shared types and constants for the 4-digit scanned display path.
// Used by the scan driver, its BCD converter and the bus interface.
package seg_disp_pkg;

   localparam int NDIG = 4;

   typedef logic [1:0] dig_idx_t;

   localparam logic [3:0] AN_NONE = 4'b1111;
   localparam logic [3:0] AN_D0   = 4'b1110;

   localparam logic [13:0] BCD_MAX    = 14'd9999;
   localparam int          CONV_STEPS = 14;

   typedef enum logic {IDLE, CONV} conv_state_t;

   // Double-dabble correction: +3 on every nibble that is 5 or more.
   function automatic logic [15:0] dd_adjust(input logic [15:0] bcd);
      logic [15:0] r;
      r = bcd;
      for (int i = 0; i < 4; i++) begin
         if (bcd[4*i +: 4] >= 4'd5)
            r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Load/scan bundle between the value source, the scan driver
// and the downstream 7-segment decoder.
interface seg_scan_driver_if;
   import seg_disp_pkg::*;

   logic            load_i;
   logic [15:0]     value_i;
   logic            dec_mode_i;
   logic            blank_lz_i;
   logic            busy_o;
   logic [3:0]      bcd_o;
   logic [NDIG-1:0] an_o;
   logic            blank_o;

   modport master (
      output load_i, value_i, dec_mode_i, blank_lz_i,
      input  busy_o, bcd_o, an_o, blank_o
   );

   modport slave (
      input  load_i, value_i, dec_mode_i, blank_lz_i,
      output busy_o, bcd_o, an_o, blank_o
   );

endinterface

// File: rtl/bin2bcd_seq.sv
// 14-bit binary to 4-digit BCD, one double-dabble step per cycle.
// done/result are valid combinationally in the final CONV cycle.
module bin2bcd_seq
   import seg_disp_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [13:0] bin,
   output logic        busy,
   output logic        done,
   output logic [15:0] result
);

   conv_state_t state;
   logic [13:0] sh;
   logic [15:0] bcd;
   logic [15:0] adj;
   logic [3:0]  cnt;

   assign adj    = dd_adjust(bcd);
   assign result = 16'({adj, sh[13]});
   assign done   = (state == CONV) && (cnt == 4'(CONV_STEPS - 1));

   // Conversion FSM: capture on start, shift CONV_STEPS times, then idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         sh    <= '0;
         bcd   <= '0;
         cnt   <= '0;
         busy  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  sh    <= bin;
                  bcd   <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= CONV;
               end
            end
            CONV: begin
               bcd <= result;
               sh  <= {sh[12:0], 1'b0};
               cnt <= cnt + 4'd1;
               if (done) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/seg_scan_driver.sv
// Latches a hex or binary display value and time-multiplexes its
// four digits with active-low anodes and leading-zero blanking.
module seg_scan_driver
   import seg_disp_pkg::*;
#(
   parameter int SCAN_DIV = 12500
) (
   input  logic              clk,
   input  logic              rst_n,
   seg_scan_driver_if.slave  bus
);

   localparam int             DW     = $clog2(SCAN_DIV);
   localparam logic [DW-1:0]  DIV_TC = DW'(SCAN_DIV - 1);

   logic [DW-1:0] div;
   dig_idx_t      idx;
   logic [15:0]   disp;
   logic          conv_busy;
   logic          conv_done;
   logic [15:0]   conv_res;
   logic          accept;
   logic          start;
   logic [13:0]   bin_clamped;
   logic [3:0]    nib;
   logic          slot_blank;

   assign accept      = bus.load_i && !conv_busy;
   assign start       = accept && bus.dec_mode_i;
   assign bin_clamped = (bus.value_i[13:0] > BCD_MAX) ?
                        BCD_MAX : bus.value_i[13:0];
   assign bus.busy_o  = conv_busy;

   bin2bcd_seq u_conv (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .bin    (bin_clamped),
      .busy   (conv_busy),
      .done   (conv_done),
      .result (conv_res)
   );

   // Free-running slot divider; digit index steps at terminal count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div <= '0;
         idx <= '0;
      end else if (div == DIV_TC) begin
         div <= '0;
         idx <= idx + 2'd1;
      end else begin
         div <= div + 1'b1;
      end
   end

   // Display register: hex loads direct, decimal only on completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         disp <= '0;
      else if (conv_done)
         disp <= conv_res;
      else if (accept && !bus.dec_mode_i)
         disp <= bus.value_i;
   end

   // Current nibble and leading-zero test for the active slot.
   always_comb begin
      nib        = 4'(disp >> {idx, 2'b00});
      slot_blank = 1'b0;
      unique case (idx)
         2'd0: slot_blank = 1'b0;
         2'd1: slot_blank = (disp[15:4]  == '0);
         2'd2: slot_blank = (disp[15:8]  == '0);
         2'd3: slot_blank = (disp[15:12] == '0);
         default: slot_blank = 1'b0;
      endcase
      slot_blank = slot_blank && bus.blank_lz_i;
   end

   // Registered digit outputs toward the segment decoder.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.bcd_o   <= 4'h0;
         bus.an_o    <= AN_D0;
         bus.blank_o <= 1'b0;
      end else begin
         bus.bcd_o   <= nib;
         bus.an_o    <= slot_blank ? AN_NONE : ~(4'b0001 << idx);
         bus.blank_o <= slot_blank;
      end
   end

endmodule
